rx_packet_isolation: RTL and testbench
======================================

Name: rx_packet_isolation

Overview:
- Parametrised store-and-forward receive buffer between the 10G MAC RX AXI-Stream output (no backpressure) and the user RX register slice.
- Forwards only complete, good frames.
- Drops frames flagged bad by the MAC (tuser=1) and frames that overflow the buffer, by rolling back the write pointer.
- Exposes drop statistics and an overflow pulse.

Parameters:
DATA_WIDTH, 64, stream data width in bits (multiple of 8)
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width
ADDR_WIDTH, 9, log2 of buffer depth in beats (DEPTH = 2**ADDR_WIDTH)
DROP_BAD, 1, 1 = drop frames ending with tuser=1; 0 = forward them unchanged
CNT_WIDTH, 16, width of each saturating drop counter

Ports:
aclk  in  1  clock for all logic
aresetn  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  DATA_WIDTH  beat from MAC
s_axis_tkeep  in  KEEP_WIDTH  byte enables
s_axis_tvalid  in  1  beat valid; no tready exists, beats cannot be stalled
s_axis_tlast  in  1  last beat of frame
s_axis_tuser  in  1  bad-frame flag, sampled only on tlast beat
m_axis_tdata  out  DATA_WIDTH  forwarded beat
m_axis_tkeep  out  KEEP_WIDTH  forwarded byte enables
m_axis_tvalid  out  1  forwarded beat valid
m_axis_tlast  out  1  forwarded last beat
m_axis_tready  in  1  downstream ready
rx_fifo_overflow  out  1  one-cycle pulse when a frame is dropped for lack of space
bad_frame_count  out  CNT_WIDTH  frames dropped for tuser=1, saturating
overflow_count  out  CNT_WIDTH  frames dropped for overflow, saturating
occupancy  out  ADDR_WIDTH+1  committed-plus-pending beats stored (wr_ptr - rd_ptr)

Behaviour:
- Interface decision: one clock, aclk; aresetn is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - wr_ptr, commit_ptr, rd_ptr = 0.
  - Write FSM = SYNC.
- Pointers are ADDR_WIDTH+1 bits.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - Data available when rd_ptr != commit_ptr.
- Each storage entry holds {tdata, tkeep, tlast}. tuser is not stored.
- Write FSM:
  - SYNC: discards beats. Goes to IDLE after a tlast beat, or after any cycle with s_axis_tvalid=0. This covers reset release in mid-frame.
  - IDLE: on valid beat with space, write the beat and wr_ptr++. If tlast, do end-of-frame handling; otherwise go to ACCEPT. On valid beat while full, go to overflow handling.
  - ACCEPT: each valid beat is written (wr_ptr++). On tlast, do end-of-frame handling and go to IDLE. A beat arriving while full triggers overflow handling.
  - DROP: discards beats until a tlast beat, then goes to IDLE.
- End-of-frame handling:
  - Good frame (tuser=0, or DROP_BAD=0): commit_ptr <= wr_ptr+1 on the tlast edge.
  - Bad frame (tuser=1 with DROP_BAD=1): wr_ptr <= commit_ptr, bad_frame_count++.
- Overflow handling:
  - wr_ptr <= commit_ptr.
  - rx_fifo_overflow=1 for one cycle.
  - overflow_count++.
  - Go to DROP. If the overflowing beat is itself tlast, go to IDLE instead.
- Frames longer than DEPTH beats are always dropped as overflow.
- Rollback never crosses rd_ptr, because reads stop at commit_ptr.
- Read side:
  - Registered output stage plus a one-entry skid, so memory read latency is hidden. Full throughput: 1 beat/cycle with m_axis_tready=1.
  - m_axis_* hold stable while tvalid=1 and tready=0.
  - Latency: the tlast beat written at edge N commits at N. The first beat of a frame into an empty buffer appears as m_axis_tvalid=1 after edge N+2.
- Simultaneous events:
  - A read and a write (including commit or rollback) in the same cycle are both honoured.
  - full is evaluated using the pre-edge rd_ptr, which is conservative.
- Counters saturate at all-ones. There is no clear other than reset.
- Asserting aresetn low mid-frame discards all stored and in-flight data immediately. The output drops tvalid asynchronously.

Test Plan:
- Three back-to-back good 8-beat frames (tuser=0), m_axis_tready=1 -> 24 beats out in order with identical tdata/tkeep/tlast; first m_axis_tvalid 2 cycles after the first frame's tlast; counters 0.
- 5-beat frame with tuser=1 on tlast, DROP_BAD=1, between two good 4-beat frames -> only 8 beats out; bad_frame_count=1; occupancy returns to 0.
- ADDR_WIDTH=4 (DEPTH=16), m_axis_tready=0, then a 10-beat and a 10-beat frame -> first frame kept; second dropped at beat 7 with a single rx_fifo_overflow pulse and overflow_count=1; after tready=1 exactly 10 beats out.
- Random m_axis_tready (50%) with continuous good frames of 1–40 beats -> no beat loss or duplication; tdata stable while stalled.
- aresetn pulsed low during beat 3 of a 6-beat frame, then released -> remaining 3 beats discarded (SYNC); next full frame forwarded intact; all counters 0.
- DROP_BAD=0 with a tuser=1 frame -> frame forwarded; bad_frame_count stays 0.

Source files
------------

// File: rtl/rx_packet_isolation.sv
// Store-and-forward RX buffer: forwards only complete good frames from a
// non-stallable MAC stream, rolling back bad or overflowing frames.
module rx_packet_isolation #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter bit          DROP_BAD   = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  rx_fifo_overflow,
  output logic [CNT_WIDTH-1:0]  bad_frame_count,
  output logic [CNT_WIDTH-1:0]  overflow_count,
  output logic [ADDR_WIDTH:0]   occupancy
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned EW    = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_DROP   = 2'd3
  } wr_state_e;

  wr_state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;

  logic full_c;
  logic bad_c;
  logic wr_en_c;
  logic bad_inc_c;
  logic ovf_c;

  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 ovf_q;
  logic [PW-1:0]        occ_q, occ_d;

  logic [EW-1:0] mem_q [DEPTH];

  // rd_ptr releases an entry only when it leaves the output stage, so space
  // held in the read pipeline still counts as occupied.
  assign full_c = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign bad_c  = DROP_BAD && s_axis_tuser;

  // Write FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Write FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: begin
        if (!s_axis_tvalid || s_axis_tlast) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACCEPT: begin
        if (s_axis_tvalid) begin
          if (s_axis_tlast)  state_d = ST_IDLE;
          else if (full_c)   state_d = ST_DROP;
          else               state_d = ST_ACCEPT;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Write FSM: pointer updates, commit / rollback and drop events
  always_comb begin
    wr_en_c      = 1'b0;
    bad_inc_c    = 1'b0;
    ovf_c        = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    if ((state_q == ST_IDLE || state_q == ST_ACCEPT) && s_axis_tvalid) begin
      if (full_c) begin
        ovf_c    = 1'b1;
        wr_ptr_d = commit_ptr_q;
      end else begin
        wr_en_c  = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (s_axis_tlast) begin
          if (bad_c) begin
            bad_inc_c = 1'b1;
            wr_ptr_d  = commit_ptr_q;
          end else begin
            commit_ptr_d = wr_ptr_q + PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    end
  end

  // Read side: one memory-read stage feeding an output register plus skid.
  logic          r1_valid_q;
  logic [EW-1:0] r1_data_q;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [EW-1:0] skid_data_q, skid_data_d;
  logic          pop_c;
  logic          avail_c;
  logic          room_c;
  logic          fetch_c;

  assign pop_c   = out_valid_q && m_axis_tready;
  assign avail_c = fetch_ptr_q != commit_ptr_q;
  // A fetch lands one cycle later, so only fetch if out+skid will still have a free slot.
  assign room_c  = (2'(out_valid_q) + 2'(skid_valid_q) + 2'(r1_valid_q) - 2'(pop_c)) <= 2'd1;
  assign fetch_c = avail_c && room_c;

  assign fetch_ptr_d = fetch_ptr_q + PW'(fetch_c);
  assign rd_ptr_d    = rd_ptr_q + PW'(pop_c);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop_c) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = r1_valid_q;
        skid_data_d  = r1_data_q;
      end else begin
        out_valid_d = r1_valid_q;
        out_data_d  = r1_data_q;
      end
    end else if (!out_valid_q) begin
      out_valid_d = r1_valid_q;
      out_data_d  = r1_data_q;
    end else if (!skid_valid_q) begin
      skid_valid_d = r1_valid_q;
      skid_data_d  = r1_data_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r1_valid_q <= 1'b0;
      r1_data_q  <= '0;
    end else begin
      r1_valid_q <= fetch_c;
      if (fetch_c) r1_data_q <= mem_q[fetch_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  // Saturating drop statistics
  always_comb begin
    bad_cnt_d = bad_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (bad_inc_c && (bad_cnt_q != '1)) bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
    if (ovf_c && (ovf_cnt_q != '1))     ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
  end

  assign occ_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      bad_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      occ_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      bad_cnt_q    <= bad_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_q        <= ovf_c;
      occ_q        <= occ_d;
    end
  end

  assign m_axis_tdata     = out_data_q[EW-1 -: DATA_WIDTH];
  assign m_axis_tkeep     = out_data_q[KEEP_WIDTH:1];
  assign m_axis_tlast     = out_data_q[0];
  assign m_axis_tvalid    = out_valid_q;
  assign rx_fifo_overflow = ovf_q;
  assign bad_frame_count  = bad_cnt_q;
  assign overflow_count   = ovf_cnt_q;
  assign occupancy        = occ_q;

endmodule

// File: tb/tb_rx_packet_isolation.sv
// Scoreboard bench for rx_packet_isolation: three instances (default, DEPTH=16,
// DROP_BAD=0) share one source bus; only the selected instance sees tvalid.
module tb_rx_packet_isolation;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic        rdy_fixed;
  logic        rand_rdy;
  logic        rnd_bit = 1'b0;
  logic        m_tready;
  int          sel;

  logic [63:0] m_tdata  [3];
  logic [7:0]  m_tkeep  [3];
  logic        m_tvalid [3];
  logic        m_tlast  [3];
  logic        ovf_p    [3];
  logic [15:0] bad_cnt  [3];
  logic [15:0] ovf_cnt  [3];
  logic [9:0]  occ0;
  logic [4:0]  occ1;
  logic [9:0]  occ2;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    first_rise_cyc = -1;
  bit    rise_seen = 1'b0;
  int    ovf_pulses = 0;
  int    ovf_cyc = -1;
  bit    stall_q = 1'b0;
  beat_t held;

  assign m_tready = rand_rdy ? rnd_bit : rdy_fixed;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  rx_packet_isolation #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .DROP_BAD(1'b1)) u_dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid && sel == 0),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready),
    .rx_fifo_overflow(ovf_p[0]), .bad_frame_count(bad_cnt[0]),
    .overflow_count(ovf_cnt[0]), .occupancy(occ0));

  rx_packet_isolation #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .DROP_BAD(1'b1)) u_small (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid && sel == 1),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready),
    .rx_fifo_overflow(ovf_p[1]), .bad_frame_count(bad_cnt[1]),
    .overflow_count(ovf_cnt[1]), .occupancy(occ1));

  rx_packet_isolation #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .DROP_BAD(1'b0)) u_nodrop (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid && sel == 2),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata[2]), .m_axis_tkeep(m_tkeep[2]), .m_axis_tvalid(m_tvalid[2]),
    .m_axis_tlast(m_tlast[2]), .m_axis_tready(m_tready),
    .rx_fifo_overflow(ovf_p[2]), .bad_frame_count(bad_cnt[2]),
    .overflow_count(ovf_cnt[2]), .occupancy(occ2));

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops, stall-hold, latency and overflow-pulse capture
  always @(negedge clk) begin
    beat_t mb;
    beat_t eb;
    mb = {m_tdata[sel], m_tkeep[sel], m_tlast[sel]};
    if (!aresetn) begin
      stall_q = 1'b0;
    end else begin
      if (ovf_p[0] || ovf_p[1] || ovf_p[2]) begin
        ovf_pulses++;
        ovf_cyc = cyc;
      end
      if (stall_q) check_eq("stall_hold", 80'({m_tvalid[sel], mb}), 80'({1'b1, held}));
      if (m_tvalid[sel] && !rise_seen) begin
        rise_seen = 1'b1;
        first_rise_cyc = cyc;
      end
      if (m_tvalid[sel] && m_tready) begin
        check_eq("sb_nonempty", 80'(exp_q.size() != 0), 80'(1));
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          check_eq("beat", 80'(mb), 80'(eb));
        end
      end
      stall_q = m_tvalid[sel] && !m_tready;
      held = mb;
    end
  end

  task automatic drive_beat(input bit last, input bit tuser, input bit fwd);
    beat_t b;
    b.d = {$urandom, $urandom};
    b.l = last;
    b.k = last ? 8'($urandom_range(1, 255)) : 8'hFF;
    s_tdata  = b.d;
    s_tkeep  = b.k;
    s_tlast  = b.l;
    s_tuser  = last ? tuser : 1'($urandom_range(0, 1));
    s_tvalid = 1'b1;
    if (fwd) exp_q.push_back(b);
  endtask

  task automatic send_frame(input int len, input bit tuser, input bit fwd,
                            output int first_edge, output int last_edge);
    first_edge = 0;
    last_edge  = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      drive_beat(i == len - 1, tuser, fwd);
      if (i == 0) first_edge = cyc + 1;
      if (i == len - 1) last_edge = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq({"drain_", tag}, 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe, le, f1_last, f2_first;
    aresetn = 1'b0; sel = 0; rdy_fixed = 1'b1; rand_rdy = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    idle(2);

    // Reset state
    check_eq("rst_tvalid", 80'(m_tvalid[0]), 80'(0));
    check_eq("rst_tdata",  80'(m_tdata[0]),  80'(0));
    check_eq("rst_occ",    80'(occ0),        80'(0));
    check_eq("rst_ovf",    80'(ovf_p[0]),    80'(0));
    check_eq("rst_badcnt", 80'(bad_cnt[0]),  80'(0));

    // Three back-to-back good 8-beat frames
    send_frame(8, 1'b0, 1'b1, fe, f1_last);
    send_frame(8, 1'b0, 1'b1, fe, le);
    send_frame(8, 1'b0, 1'b1, fe, le);
    idle(1);
    drain("b2b");
    check_eq("latency", 80'(first_rise_cyc), 80'(f1_last + 2));
    check_eq("b2b_badcnt", 80'(bad_cnt[0]), 80'(0));
    check_eq("b2b_ovfcnt", 80'(ovf_cnt[0]), 80'(0));

    // Bad frame between two good ones
    send_frame(4, 1'b0, 1'b1, fe, le);
    send_frame(5, 1'b1, 1'b0, fe, le);
    send_frame(4, 1'b0, 1'b1, fe, le);
    idle(1);
    drain("bad");
    check_eq("bad_badcnt", 80'(bad_cnt[0]), 80'(1));
    check_eq("bad_occ",    80'(occ0),       80'(0));

    // DEPTH=16 overflow with output stalled
    sel = 1; rdy_fixed = 1'b0;
    send_frame(10, 1'b0, 1'b1, fe, le);
    send_frame(10, 1'b0, 1'b0, f2_first, le);
    idle(4);
    check_eq("ovf_pulses", 80'(ovf_pulses), 80'(1));
    check_eq("ovf_at_beat7", 80'(ovf_cyc), 80'(f2_first + 6));
    check_eq("ovf_cnt", 80'(ovf_cnt[1]), 80'(1));
    check_eq("ovf_occ", 80'(occ1), 80'(10));
    rdy_fixed = 1'b1;
    drain("ovf");
    check_eq("ovf_occ_end", 80'(occ1), 80'(0));
    check_eq("ovf_badcnt",  80'(bad_cnt[1]), 80'(0));

    // Random ready, continuous good frames 1..40 beats
    sel = 0; rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) begin
      send_frame($urandom_range(1, 40), 1'b0, 1'b1, fe, le);
      idle($urandom_range(0, 2));
    end
    idle(1);
    drain("rand");
    rand_rdy = 1'b0;
    check_eq("rand_ovfcnt", 80'(ovf_cnt[0]), 80'(0));
    check_eq("rand_occ",    80'(occ0),       80'(0));

    // Reset mid-frame while a stalled frame sits in the output stage
    rdy_fixed = 1'b0;
    send_frame(3, 1'b0, 1'b1, fe, le);
    idle(4);
    check_eq("pre_rst_tvalid", 80'(m_tvalid[0]), 80'(1));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive_beat(i == 5, 1'b0, 1'b0);
      if (i == 2) begin
        aresetn = 1'b0;
        exp_q.delete();
        #1;
        check_eq("async_tvalid", 80'(m_tvalid[0]), 80'(0));
        check_eq("rst_occ_mid",  80'(occ0),        80'(0));
        check_eq("rst_clr_ovf",  80'(ovf_cnt[1]),  80'(0));
      end
      if (i == 3) begin
        aresetn = 1'b1;
        rdy_fixed = 1'b1;
      end
    end
    send_frame(6, 1'b0, 1'b1, fe, le);
    idle(1);
    drain("rst");
    check_eq("rst_badcnt_end", 80'(bad_cnt[0]), 80'(0));
    check_eq("rst_ovfcnt_end", 80'(ovf_cnt[0]), 80'(0));

    // DROP_BAD=0 forwards a tuser=1 frame
    sel = 2;
    send_frame(5, 1'b1, 1'b1, fe, le);
    idle(1);
    drain("nodrop");
    check_eq("nodrop_badcnt", 80'(bad_cnt[2]), 80'(0));
    check_eq("total_ovf_pulses", 80'(ovf_pulses), 80'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
